// File: rtl/ef_sram_pkg.sv
// -----------------------------------------------------------------------------
// ef_sram_pkg
// Shared constants and types for the fabric-to-SRAM-macro bridge.
//   EF_SRAM_AW / EF_SRAM_DW : default word-address and data widths
//   ef_sram_state_e         : bridge FSM state encoding
// Optional build macro: EF_SRAM_RDATA_REG_EN adds the ST_RD_PIPE state, which
// registers the macro read data once more before it reaches the response buffer.
// -----------------------------------------------------------------------------
package ef_sram_pkg;

    localparam int unsigned EF_SRAM_AW = 10;
    localparam int unsigned EF_SRAM_DW = 32;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RD_WAIT = 2'd1,
`ifdef EF_SRAM_RDATA_REG_EN
        ST_RD_PIPE = 2'd2,
`endif
        ST_RSP     = 2'd3
    } ef_sram_state_e;

endpackage

// File: rtl/ef_sram_rsp_buf.sv
// -----------------------------------------------------------------------------
// ef_sram_rsp_buf
// Read response holding register with valid/ready handshake.
//   clk, rst_n     : clock, asynchronous active-low reset
//   load           : capture load_data and raise rsp_valid
//   load_data      : read data to present
//   rsp_ready      : fabric accepts the response
//   rsp_valid      : response pending (registered)
//   rsp_rdata      : response data (registered, kept after the handshake)
//   rsp_done       : response handshake happens this cycle
// -----------------------------------------------------------------------------
module ef_sram_rsp_buf
    import ef_sram_pkg::*;
#(
    parameter int unsigned DW = EF_SRAM_DW
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          load,
    input  logic [DW-1:0] load_data,
    input  logic          rsp_ready,
    output logic          rsp_valid,
    output logic [DW-1:0] rsp_rdata,
    output logic          rsp_done
);

    logic          rsp_valid_q;
    logic          rsp_valid_d;
    logic [DW-1:0] rsp_rdata_q;
    logic [DW-1:0] rsp_rdata_d;

    // Handshake only counts while a response is pending, so a stray rsp_ready is ignored.
    assign rsp_done = rsp_valid_q & rsp_ready;

    // Next-state for the valid flag and data register; data is never cleared by a handshake.
    always_comb begin
        rsp_valid_d = rsp_valid_q;
        rsp_rdata_d = rsp_rdata_q;
        if (load) begin
            rsp_valid_d = 1'b1;
            rsp_rdata_d = load_data;
        end else if (rsp_done) begin
            rsp_valid_d = 1'b0;
        end else begin
            rsp_valid_d = rsp_valid_q;
        end
    end

    // Response state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= {DW{1'b0}};
        end else begin
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;

endmodule

// File: rtl/s_term_ef_sram_bridge.sv
// -----------------------------------------------------------------------------
// s_term_ef_sram_bridge
// Bridges a valid/ready fabric request port onto a single-port SRAM macro with
// one-cycle read latency. Writes complete in the accept cycle (one per cycle);
// reads block the request port until the response has been handed over.
//   UserCLK, resetn           : clock, asynchronous active-low reset
//   req_valid/req_ready       : request handshake
//   req_we, req_addr,
//   req_wdata, req_be         : request payload (be used for writes only)
//   rsp_valid/rsp_ready       : read response handshake
//   rsp_rdata                 : read response data
//   sram_en, sram_we,
//   sram_addr, sram_wdata     : macro access, driven combinationally on accept
//   sram_rdata                : macro read data, valid the cycle after access
// Optional build macro: EF_SRAM_RDATA_REG_EN inserts an extra read-data register
// stage (state ST_RD_PIPE), moving read latency from T+2 to T+3.
// -----------------------------------------------------------------------------
module s_term_ef_sram_bridge
    import ef_sram_pkg::*;
#(
    parameter int unsigned AW = EF_SRAM_AW,
    parameter int unsigned DW = EF_SRAM_DW
) (
    input  logic            UserCLK,
    input  logic            resetn,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic            req_we,
    input  logic [AW-1:0]   req_addr,
    input  logic [DW-1:0]   req_wdata,
    input  logic [DW/8-1:0] req_be,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic [DW-1:0]   rsp_rdata,
    output logic            sram_en,
    output logic [DW/8-1:0] sram_we,
    output logic [AW-1:0]   sram_addr,
    output logic [DW-1:0]   sram_wdata,
    input  logic [DW-1:0]   sram_rdata
);

    localparam int unsigned BW = DW / 8;

    ef_sram_state_e state_q;
    ef_sram_state_e state_d;
    logic           ready_en_q;
    logic           ready_en_d;
    logic           hs_s;
    logic           rsp_load_s;
    logic [DW-1:0]  rsp_load_data_s;
    logic           rsp_done_s;
`ifdef EF_SRAM_RDATA_REG_EN
    logic [DW-1:0]  pipe_q;
    logic [DW-1:0]  pipe_d;
`endif

    // ready_en_q holds req_ready low through reset and releases it on the first
    // clock edge after resetn rises, even though the FSM already sits in IDLE.
    assign ready_en_d = 1'b1;
    assign req_ready  = ready_en_q & (state_q == ST_IDLE);
    assign hs_s       = req_valid & req_ready;

    // Address and data are passed straight through; only en/we qualify an access.
    assign sram_addr  = req_addr;
    assign sram_wdata = req_wdata;

    // Macro strobes: a write with no byte enabled is consumed without touching the macro.
    always_comb begin
        sram_en = 1'b0;
        sram_we = {BW{1'b0}};
        if (hs_s) begin
            if (req_we) begin
                sram_en = |req_be;
                sram_we = req_be;
            end else begin
                sram_en = 1'b1;
                sram_we = {BW{1'b0}};
            end
        end else begin
            sram_en = 1'b0;
            sram_we = {BW{1'b0}};
        end
    end

    // FSM next-state and response-buffer load control.
    always_comb begin
        state_d         = state_q;
        rsp_load_s      = 1'b0;
        rsp_load_data_s = sram_rdata;
`ifdef EF_SRAM_RDATA_REG_EN
        pipe_d          = pipe_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (hs_s && !req_we) begin
                    state_d = ST_RD_WAIT;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RD_WAIT: begin
`ifdef EF_SRAM_RDATA_REG_EN
                pipe_d  = sram_rdata;
                state_d = ST_RD_PIPE;
`else
                rsp_load_s      = 1'b1;
                rsp_load_data_s = sram_rdata;
                state_d         = ST_RSP;
`endif
            end
`ifdef EF_SRAM_RDATA_REG_EN
            ST_RD_PIPE: begin
                rsp_load_s      = 1'b1;
                rsp_load_data_s = pipe_q;
                state_d         = ST_RSP;
            end
`endif
            ST_RSP: begin
                if (rsp_done_s) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_RSP;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // FSM and ready-enable registers.
    always_ff @(posedge UserCLK or negedge resetn) begin
        if (!resetn) begin
            state_q    <= ST_IDLE;
            ready_en_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            ready_en_q <= ready_en_d;
        end
    end

`ifdef EF_SRAM_RDATA_REG_EN
    // Extra read-data stage between the macro and the response buffer.
    always_ff @(posedge UserCLK or negedge resetn) begin
        if (!resetn) begin
            pipe_q <= {DW{1'b0}};
        end else begin
            pipe_q <= pipe_d;
        end
    end
`endif

    ef_sram_rsp_buf #(
        .DW (DW)
    ) u_rsp_buf (
        .clk       (UserCLK),
        .rst_n     (resetn),
        .load      (rsp_load_s),
        .load_data (rsp_load_data_s),
        .rsp_ready (rsp_ready),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_done  (rsp_done_s)
    );

endmodule

// File: tb/tb_s_term_ef_sram_bridge.sv
// -----------------------------------------------------------------------------
// tb_s_term_ef_sram_bridge
// Drives the bridge against a behavioural SRAM macro and checks every request
// against a word-array reference memory updated from byte-enable semantics.
// -----------------------------------------------------------------------------
module tb_s_term_ef_sram_bridge;

    localparam int AW = 10;
    localparam int DW = 32;
    localparam int BW = DW / 8;
`ifdef EF_SRAM_RDATA_REG_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 2;
`endif

    logic            UserCLK = 1'b0;
    logic            resetn;
    logic            req_valid;
    logic            req_ready;
    logic            req_we;
    logic [AW-1:0]   req_addr;
    logic [DW-1:0]   req_wdata;
    logic [BW-1:0]   req_be;
    logic            rsp_valid;
    logic            rsp_ready;
    logic [DW-1:0]   rsp_rdata;
    logic            sram_en;
    logic [BW-1:0]   sram_we;
    logic [AW-1:0]   sram_addr;
    logic [DW-1:0]   sram_wdata;
    logic [DW-1:0]   sram_rdata;

    logic            mem_clr;
    logic [DW-1:0]   sram_mem [0:(1<<AW)-1];
    logic [DW-1:0]   ref_mem  [0:(1<<AW)-1];
    logic [DW-1:0]   mdl_w;

    int vectors;
    int miscompares;

    always #5 UserCLK = ~UserCLK;

    s_term_ef_sram_bridge #(.AW(AW), .DW(DW)) dut (
        .UserCLK    (UserCLK),
        .resetn     (resetn),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_be     (req_be),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_rdata  (rsp_rdata),
        .sram_en    (sram_en),
        .sram_we    (sram_we),
        .sram_addr  (sram_addr),
        .sram_wdata (sram_wdata),
        .sram_rdata (sram_rdata)
    );

    // Behavioural single-port macro: byte writes, registered read data.
    always @(posedge UserCLK) begin
        if (mem_clr) begin
            for (int i = 0; i < (1 << AW); i++) sram_mem[i] <= '0;
            sram_rdata <= '0;
        end else if (sram_en) begin
            if (sram_we == '0) begin
                sram_rdata <= sram_mem[sram_addr];
            end else begin
                mdl_w = sram_mem[sram_addr];
                for (int b = 0; b < BW; b++)
                    if (sram_we[b]) mdl_w[8*b +: 8] = sram_wdata[8*b +: 8];
                sram_mem[sram_addr] <= mdl_w;
            end
        end
    end

    task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d,
                            input logic [BW-1:0] be, input string tag);
        req_valid = 1'b1; req_we = 1'b1; req_addr = a; req_wdata = d; req_be = be;
        #1;
        vectors++; if (req_ready !== 1'b1) begin miscompares++; $display("FAIL %s wr_ready: got %b expected 1", tag, req_ready); end
        vectors++; if (sram_en !== (be != '0)) begin miscompares++; $display("FAIL %s wr_en: got %b expected %b", tag, sram_en, (be != '0)); end
        vectors++; if (sram_we !== be) begin miscompares++; $display("FAIL %s wr_we: got %h expected %h", tag, sram_we, be); end
        if (be != '0) begin
            vectors++; if (sram_addr !== a || sram_wdata !== d) begin miscompares++; $display("FAIL %s wr_addr_data: got %h/%h expected %h/%h", tag, sram_addr, sram_wdata, a, d); end
        end
        for (int b = 0; b < BW; b++) if (be[b]) ref_mem[a][8*b +: 8] = d[8*b +: 8];
        @(posedge UserCLK); #1;
    endtask

    task automatic do_read(input logic [AW-1:0] a, input int hold, input string tag);
        logic [DW-1:0] exp_d;
        logic [DW-1:0] held;
        int cyc;
        exp_d = ref_mem[a];
        rsp_ready = 1'b0;
        req_valid = 1'b1; req_we = 1'b0; req_addr = a; req_be = BW'($urandom);
        #1;
        vectors++; if (req_ready !== 1'b1) begin miscompares++; $display("FAIL %s rd_ready: got %b expected 1", tag, req_ready); end
        vectors++; if (sram_en !== 1'b1 || sram_we !== '0 || sram_addr !== a) begin miscompares++; $display("FAIL %s rd_access: got en=%b we=%h addr=%h expected en=1 we=0 addr=%h", tag, sram_en, sram_we, sram_addr, a); end
        @(posedge UserCLK); #1;
        req_valid = $urandom_range(0, 1);
        req_we = 1'b0;
        #1;
        cyc = 1;
        while (rsp_valid !== 1'b1 && cyc < 10) begin
            vectors++; if (req_ready !== 1'b0 || sram_en !== 1'b0) begin miscompares++; $display("FAIL %s rd_busy: got ready=%b en=%b expected 0/0", tag, req_ready, sram_en); end
            @(posedge UserCLK); #2;
            cyc++;
        end
        req_valid = 1'b0;
        if (rsp_valid !== 1'b1) begin
            vectors++; miscompares++;
            $display("FAIL %s rd_timeout: got no rsp_valid expected within %0d cycles", tag, LAT);
            return;
        end
        vectors++; if (cyc != LAT) begin miscompares++; $display("FAIL %s rd_latency: got %0d expected %0d", tag, cyc, LAT); end
        vectors++; if (rsp_rdata !== exp_d) begin miscompares++; $display("FAIL %s rd_data: got %h expected %h", tag, rsp_rdata, exp_d); end
        held = rsp_rdata;
        for (int i = 0; i < hold; i++) begin
            @(posedge UserCLK); #2;
            vectors++; if (rsp_valid !== 1'b1 || rsp_rdata !== held || req_ready !== 1'b0) begin miscompares++; $display("FAIL %s rd_hold: got v=%b d=%h rdy=%b expected 1/%h/0", tag, rsp_valid, rsp_rdata, req_ready, held); end
        end
        rsp_ready = 1'b1;
        #1;
        vectors++; if (req_ready !== 1'b0) begin miscompares++; $display("FAIL %s rd_ready_in_hs: got %b expected 0", tag, req_ready); end
        @(posedge UserCLK); #1;
        rsp_ready = 1'b0;
        #1;
        vectors++; if (rsp_valid !== 1'b0 || req_ready !== 1'b1 || rsp_rdata !== held) begin miscompares++; $display("FAIL %s rd_after: got v=%b rdy=%b d=%h expected 0/1/%h", tag, rsp_valid, req_ready, rsp_rdata, held); end
    endtask

    task automatic test_reset();
        resetn = 1'b0; mem_clr = 1'b1;
        req_valid = 1'b1; req_we = 1'b0; req_addr = '0; req_wdata = '0; req_be = '1; rsp_ready = 1'b1;
        for (int i = 0; i < (1 << AW); i++) ref_mem[i] = '0;
        repeat (3) @(posedge UserCLK);
        #2;
        vectors++; if (req_ready !== 1'b0) begin miscompares++; $display("FAIL rst_ready: got %b expected 0", req_ready); end
        vectors++; if (rsp_valid !== 1'b0 || rsp_rdata !== '0) begin miscompares++; $display("FAIL rst_rsp: got v=%b d=%h expected 0/0", rsp_valid, rsp_rdata); end
        vectors++; if (sram_en !== 1'b0 || sram_we !== '0) begin miscompares++; $display("FAIL rst_sram: got en=%b we=%h expected 0/0", sram_en, sram_we); end
        mem_clr = 1'b0; req_valid = 1'b0; rsp_ready = 1'b0;
        @(negedge UserCLK); resetn = 1'b1; #1;
        vectors++; if (req_ready !== 1'b0) begin miscompares++; $display("FAIL rst_release_early: got %b expected 0", req_ready); end
        @(posedge UserCLK); #1;
        vectors++; if (req_ready !== 1'b1) begin miscompares++; $display("FAIL rst_release: got %b expected 1", req_ready); end
    endtask

    task automatic test_directed();
        do_write(10'h005, 32'hDEADBEEF, 4'hF, "wr_full");
        req_valid = 1'b0; #1;
        do_read(10'h005, 0, "rd_full");
        vectors++; if (rsp_rdata !== 32'hDEADBEEF) begin miscompares++; $display("FAIL rd_full_const: got %h expected DEADBEEF", rsp_rdata); end
        do_write(10'h005, 32'h000000AA, 4'h1, "wr_byte");
        req_valid = 1'b0; #1;
        do_read(10'h005, 0, "rd_byte");
        vectors++; if (rsp_rdata !== 32'hDEADBEAA) begin miscompares++; $display("FAIL rd_byte_const: got %h expected DEADBEAA", rsp_rdata); end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 4; i++)
            do_write(AW'(16 + i), $urandom, 4'hF, "b2b");
        req_valid = 1'b0; #1;
        for (int i = 0; i < 4; i++) do_read(AW'(16 + i), 0, "b2b_rd");
    endtask

    task automatic test_backpressure();
        do_write(10'h020, 32'h12345678, 4'hF, "bp_wr");
        req_valid = 1'b0; #1;
        do_read(10'h020, 5, "bp_rd");
    endtask

    task automatic test_be_zero();
        do_write(10'h005, 32'hFFFFFFFF, 4'h0, "be0");
        req_valid = 1'b0; #1;
        vectors++; if (req_ready !== 1'b1) begin miscompares++; $display("FAIL be0_ready_after: got %b expected 1", req_ready); end
        do_read(10'h005, 1, "be0_rd");
    endtask

    task automatic test_idle_rsp_ready();
        rsp_ready = 1'b1;
        repeat (3) begin
            @(posedge UserCLK); #2;
            vectors++; if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin miscompares++; $display("FAIL idle_rsp_ready: got v=%b rdy=%b expected 0/1", rsp_valid, req_ready); end
        end
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset_mid_read();
        req_valid = 1'b1; req_we = 1'b0; req_addr = 10'h005; req_be = 4'h0;
        @(posedge UserCLK); #1;
        req_valid = 1'b0;
        resetn = 1'b0; #1;
        vectors++; if (rsp_valid !== 1'b0 || rsp_rdata !== '0 || req_ready !== 1'b0) begin miscompares++; $display("FAIL midrst_in: got v=%b d=%h rdy=%b expected 0/0/0", rsp_valid, rsp_rdata, req_ready); end
        @(posedge UserCLK);
        @(negedge UserCLK); resetn = 1'b1; #1;
        vectors++; if (req_ready !== 1'b0) begin miscompares++; $display("FAIL midrst_early: got %b expected 0", req_ready); end
        @(posedge UserCLK); #1;
        vectors++; if (req_ready !== 1'b1) begin miscompares++; $display("FAIL midrst_ready: got %b expected 1", req_ready); end
        repeat (4) begin
            vectors++; if (rsp_valid !== 1'b0 || rsp_rdata !== '0) begin miscompares++; $display("FAIL midrst_no_rsp: got v=%b d=%h expected 0/0", rsp_valid, rsp_rdata); end
            @(posedge UserCLK); #1;
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 60; n++) begin
            if ($urandom_range(0, 1) == 1) begin
                do_write(AW'($urandom_range(0, 15)), $urandom, BW'($urandom), "rnd_wr");
                if ($urandom_range(0, 2) == 0) begin req_valid = 1'b0; #1; end
            end else begin
                req_valid = 1'b0; #1;
                do_read(AW'($urandom_range(0, 15)), $urandom_range(0, 3), "rnd_rd");
            end
        end
        req_valid = 1'b0;
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        test_reset();
        test_directed();
        test_back_to_back();
        test_backpressure();
        test_be_zero();
        test_idle_rsp_ready();
        test_reset_mid_read();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no completion expected finish before 500000");
        $fatal(1);
    end

endmodule

// File: doc/s_term_ef_sram_bridge.md
S_TERM_EF_SRAM_BRIDGE -- requirements
Module: s_term_ef_sram_bridge

Interface
REQ-001 SHALL have parameter AW, default 10, meaning the SRAM word-address width.
REQ-002 SHALL have parameter DW, default 32, meaning the data width, fixed at a multiple of 8.
REQ-003 SHALL have port UserCLK, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port resetn, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port req_valid, input, 1 bit: fabric request valid.
REQ-006 SHALL have port req_ready, output, 1 bit: bridge accepts the request this cycle.
REQ-007 SHALL have port req_we, input, 1 bit: 1 = write, 0 = read.
REQ-008 SHALL have port req_addr, input, AW bits: word address.
REQ-009 SHALL have port req_wdata, input, DW bits: write data.
REQ-010 SHALL have port req_be, input, DW/8 bits: byte enables for writes.
REQ-011 SHALL have port rsp_valid, output, 1 bit: read data valid.
REQ-012 SHALL have port rsp_ready, input, 1 bit: fabric accepts the response.
REQ-013 SHALL have port rsp_rdata, output, DW bits: read data.
REQ-014 SHALL have port sram_en, output, 1 bit: macro access enable.
REQ-015 SHALL have port sram_we, output, DW/8 bits: macro byte write enables.
REQ-016 SHALL have port sram_addr, output, AW bits: macro address.
REQ-017 SHALL have port sram_wdata, output, DW bits: macro write data.
REQ-018 SHALL have port sram_rdata, input, DW bits: macro read data, valid the cycle after the access.

Function
REQ-019 SHALL implement FSM states IDLE, RD_WAIT, [RD_PIPE], RSP.
REQ-020 SHALL assert req_ready only in IDLE; a handshake is req_valid & req_ready.
REQ-021 SHALL drive sram_en, sram_addr, sram_wdata and sram_we combinationally in the handshake cycle; sram_en=0 and sram_we=0 in every other cycle.
REQ-022 On a write handshake with req_be != 0, SHALL set sram_we=req_be and stay in IDLE, allowing back-to-back writes at one per cycle.
REQ-023 On a write handshake with req_be == 0, SHALL keep sram_en=0 and consume the request without any macro access.
REQ-024 On a read handshake, SHALL set sram_we=0 and go IDLE -> RD_WAIT.
REQ-025 In RD_WAIT, SHALL capture sram_rdata into the response register and go to RSP.
REQ-026 In RSP, SHALL hold rsp_valid=1 with stable rsp_rdata until rsp_ready=1, then return to IDLE.
REQ-027 Read accepted in cycle T: rsp_valid SHALL be high from cycle T+2; the next request SHALL be accepted no earlier than the cycle after the response handshake.
REQ-028 rsp_rdata SHALL keep its last captured value after the handshake.
REQ-029 rsp_ready asserted while rsp_valid=0 SHALL have no effect.

Reset
REQ-030 While resetn=0, SHALL force: state IDLE; req_ready=0; rsp_valid=0; rsp_rdata=0; sram_en=0; sram_we=0.
REQ-031 req_ready SHALL first assert in the cycle after resetn deasserts.
REQ-032 Reset asserted during RD_WAIT, RD_PIPE or RSP SHALL discard the pending response with no rsp_valid pulse.

Configuration
REQ-033 Macro EF_SRAM_RDATA_REG_EN, when defined, SHALL add state RD_PIPE between RD_WAIT and RSP, registering sram_rdata once more; read latency becomes T+3.
REQ-034 Without EF_SRAM_RDATA_REG_EN, RD_PIPE SHALL not exist and read latency SHALL be T+2.

Structure
REQ-035 Package ef_sram_pkg SHALL hold the default AW/DW constants and the FSM state enum typedef.
REQ-036 Sub-module ef_sram_rsp_buf SHALL contain the response register, rsp_valid flag and handshake logic; the FSM stays in the top module.

Verification
REQ-037 Write 0xDEADBEEF to addr 0x005 with be=0xF, then read addr 0x005 -> rsp_rdata=0xDEADBEEF at T+2 (T+3 with the macro).
REQ-038 Write 0x000000AA to addr 0x005 with be=0x1 over 0xDEADBEEF, then read -> 0xDEADBEAA.
REQ-039 Four back-to-back writes with req_valid held high -> four consecutive sram_en pulses with req_ready=1 throughout.
REQ-040 Read with rsp_ready held low for 5 cycles -> rsp_valid and rsp_rdata stable for all 5 cycles, and req_ready=0 until the handshake.
REQ-041 Write with be=0x0 -> sram_en stays 0 and req_ready stays 1.
REQ-042 Read accepted, then resetn pulsed low in RD_WAIT -> no rsp_valid, rsp_rdata=0, and req_ready=1 one cycle after release.
